conv3x3_pe: RTL and testbench

CONV3X3_PE -- requirements
Module: conv3x3_pe

---
 rtl/conv3x3_pe.sv | 148 ++++++++++++++
 tb/tb_conv3x3_pe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_pe.sv
// 3x3 convolution processing element: nine signed MACs per window, channel
// accumulation into a saturating group partial sum with three pipeline stages.
module conv3x3_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_TAPS   = 9,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] wgt_in [NUM_TAPS],
  input  logic                         wgt_load,
  input  logic signed [DATA_WIDTH-1:0] act_in [NUM_TAPS],
  input  logic                         act_valid,
  input  logic                         act_last,
  output logic signed [ACC_WIDTH-1:0]  psum_out,
  output logic                         psum_valid,
  output logic                         sat,
  output logic [CNT_WIDTH-1:0]         grp_cnt
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + 4;
  // One guard bit above the wider of accumulator and window sum, so the raw add never wraps.
  localparam int EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  localparam logic signed [EXT_W-1:0] ACC_MAX =
    {{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    {{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  // Returns {clamped, value}.
  function automatic logic [ACC_WIDTH:0] sat_acc(input logic signed [EXT_W-1:0] x);
    if (x > ACC_MAX) return {1'b1, ACC_MAX[ACC_WIDTH-1:0]};
    if (x < ACC_MIN) return {1'b1, ACC_MIN[ACC_WIDTH-1:0]};
    return {1'b0, x[ACC_WIDTH-1:0]};
  endfunction

  logic signed [DATA_WIDTH-1:0] r_wgt     [NUM_TAPS];
  logic signed [PROD_W-1:0]     w_prod    [NUM_TAPS];
  logic signed [PROD_W-1:0]     r_prod_p1 [NUM_TAPS];
  logic                         r_vld_p1;
  logic                         r_last_p1;
  logic signed [SUM_W-1:0]      w_sum;
  logic signed [SUM_W-1:0]      r_sum_p2;
  logic                         r_vld_p2;
  logic                         r_last_p2;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_sat_grp;
  logic [CNT_WIDTH-1:0]         r_cnt;
  logic signed [ACC_WIDTH-1:0]  r_psum;
  logic                         r_psum_vld;
  logic                         r_sat;
  logic signed [EXT_W-1:0]      w_acc_ext;
  logic signed [EXT_W-1:0]      w_sum_ext;
  logic signed [EXT_W-1:0]      w_raw;
  logic [ACC_WIDTH:0]           w_sat_res;
  logic signed [ACC_WIDTH-1:0]  w_res;
  logic                         w_clamp;

  // Weight registers; a window in the load cycle still multiplies the old set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_wgt[i] <= '0;
    end else if (wgt_load) begin
      for (int i = 0; i < NUM_TAPS; i++) r_wgt[i] <= wgt_in[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_prod[i] = PROD_W'(act_in[i]) * PROD_W'(r_wgt[i]);
    end
  end

  // Stage p1: per-tap products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_prod_p1[i] <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) r_prod_p1[i] <= w_prod[i];
      r_vld_p1  <= act_valid;
      r_last_p1 <= act_valid & act_last;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_sum = w_sum + SUM_W'(r_prod_p1[i]);
    end
  end

  // Stage p2: window sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p2  <= '0;
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
    end else begin
      r_sum_p2  <= w_sum;
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
    end
  end

  assign w_acc_ext = {{(EXT_W-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
  assign w_sum_ext = {{(EXT_W-SUM_W){r_sum_p2[SUM_W-1]}}, r_sum_p2};
  assign w_raw     = w_acc_ext + w_sum_ext;
  assign w_sat_res = sat_acc(w_raw);
  assign w_clamp   = w_sat_res[ACC_WIDTH];
  assign w_res     = w_sat_res[ACC_WIDTH-1:0];

  // Stage p3: accumulate; the accumulator is left at zero after each group closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_sat_grp  <= 1'b0;
      r_cnt      <= '0;
      r_psum     <= '0;
      r_sat      <= 1'b0;
      r_psum_vld <= 1'b0;
    end else begin
      r_psum_vld <= r_vld_p2 & r_last_p2;
      if (r_vld_p2) begin
        if (r_last_p2) begin
          r_psum    <= w_res;
          r_sat     <= r_sat_grp | w_clamp;
          r_acc     <= '0;
          r_sat_grp <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_acc     <= w_res;
          r_sat_grp <= r_sat_grp | w_clamp;
          r_cnt     <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign psum_out   = r_psum;
  assign psum_valid = r_psum_vld;
  assign sat        = r_sat;
  assign grp_cnt    = r_cnt;

endmodule

// File: tb/tb_conv3x3_pe.sv
// Bench for conv3x3_pe: table vectors, directed corner sequences and random
// traffic, checked against a group-level dot-product model (32- and 16-bit acc).
module tb_conv3x3_pe;

  localparam int DW = 8;
  localparam int NC = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic signed [DW-1:0] wgt_in [9];
  logic signed [DW-1:0] act_in [9];
  logic wgt_load = 1'b0;
  logic act_valid = 1'b0;
  logic act_last = 1'b0;

  logic signed [31:0] psum_a;
  logic               pv_a, sat_a;
  logic [7:0]         cnt_a;
  logic signed [15:0] psum_b;
  logic               pv_b, sat_b;
  logic [7:0]         cnt_b;

  conv3x3_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .NUM_TAPS(9), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wgt_in(wgt_in), .wgt_load(wgt_load),
    .act_in(act_in), .act_valid(act_valid), .act_last(act_last),
    .psum_out(psum_a), .psum_valid(pv_a), .sat(sat_a), .grp_cnt(cnt_a));

  conv3x3_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .NUM_TAPS(9), .CNT_WIDTH(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .wgt_in(wgt_in), .wgt_load(wgt_load),
    .act_in(act_in), .act_valid(act_valid), .act_last(act_last),
    .psum_out(psum_b), .psum_valid(pv_b), .sat(sat_b), .grp_cnt(cnt_b));

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int checks = 0;
  int errors = 0;

  // stimulus values and model state
  int t_wgt [9];
  int t_act [9];
  int mw [9];
  int accw [2] = '{32, 16};
  longint gacc [2];
  bit     gsat [2];
  int     gcnt [2];
  // expected stage-3 events, indexed by the clock edge that produces them
  bit     ev  [2][NC];
  bit     evl [2][NC];
  longint evp [2][NC];
  bit     evs [2][NC];
  int     evc [2][NC];
  // expected held outputs
  longint hp [2];
  bit     hs [2];
  int     hcnt [2];
  // captured completed results
  longint cap_p [2];
  bit     cap_s [2];
  int     npulse [2];

  typedef struct {
    int w; int a; int n; bit bub;
    longint e32; bit s32; longint e16; bit s16;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, edges, got, exp);
    end
  endtask

  function automatic longint clampw(input longint x, input int w, output bit c);
    longint mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -(64'sd1 <<< (w - 1));
    c = 1'b1;
    if (x > mx) return mx;
    if (x < mn) return mn;
    c = 1'b0;
    return x;
  endfunction

  task automatic check();
    int k;
    bit expv [2];
    k = edges;
    if (k >= NC - 4) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", k, NC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    for (int m = 0; m < 2; m++) begin
      expv[m] = 1'b0;
      if (ev[m][k]) begin
        hcnt[m] = evc[m][k];
        if (evl[m][k]) begin
          hp[m] = evp[m][k];
          hs[m] = evs[m][k];
          expv[m] = 1'b1;
        end
      end
    end
    chk("valid32", longint'(pv_a), longint'(expv[0]));
    chk("psum32",  longint'(psum_a), hp[0]);
    chk("sat32",   longint'(sat_a), longint'(hs[0]));
    chk("cnt32",   longint'(cnt_a), longint'(hcnt[0]));
    chk("valid16", longint'(pv_b), longint'(expv[1]));
    chk("psum16",  longint'(psum_b), hp[1]);
    chk("sat16",   longint'(sat_b), longint'(hs[1]));
    chk("cnt16",   longint'(cnt_b), longint'(hcnt[1]));
    if (pv_a) begin npulse[0]++; cap_p[0] = longint'(psum_a); cap_s[0] = sat_a; end
    if (pv_b) begin npulse[1]++; cap_p[1] = longint'(psum_b); cap_s[1] = sat_b; end
  endtask

  task automatic model(input bit ld, input bit v, input bit l);
    longint dot, x, r;
    bit c;
    int k;
    if (v) begin
      dot = 0;
      for (int i = 0; i < 9; i++) dot += longint'(t_act[i]) * longint'(mw[i]);
      k = edges + 3;
      for (int m = 0; m < 2; m++) begin
        x = gacc[m] + dot;
        r = clampw(x, accw[m], c);
        gsat[m] = gsat[m] | c;
        ev[m][k] = 1'b1;
        evl[m][k] = l;
        if (l) begin
          evp[m][k] = r;
          evs[m][k] = gsat[m];
          gacc[m] = 0;
          gsat[m] = 1'b0;
          gcnt[m] = 0;
        end else begin
          gacc[m] = r;
          gcnt[m] = (gcnt[m] + 1) % 256;
        end
        evc[m][k] = gcnt[m];
      end
    end
    if (ld) mw = t_wgt;
  endtask

  task automatic apply(input bit ld, input bit v, input bit l);
    for (int i = 0; i < 9; i++) begin
      wgt_in[i] = DW'(t_wgt[i]);
      act_in[i] = DW'(t_act[i]);
    end
    wgt_load = ld;
    act_valid = v;
    act_last = l;
  endtask

  task automatic step(input bit ld, input bit v, input bit l);
    @(negedge clk);
    check();
    apply(ld, v, l);
    model(ld, v, l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check();
    rst_n = 1'b0;
    apply(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) mw[i] = 0;
    for (int m = 0; m < 2; m++) begin
      gacc[m] = 0; gsat[m] = 1'b0; gcnt[m] = 0;
      hp[m] = 0; hs[m] = 1'b0; hcnt[m] = 0;
      for (int k = edges + 1; k < NC; k++) ev[m][k] = 1'b0;
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check();
    rst_n = 1'b1;
  endtask

  task automatic set_all(input int w, input int a);
    for (int i = 0; i < 9; i++) begin t_wgt[i] = w; t_act[i] = a; end
  endtask

  initial begin
    int p0, p1;
    tbl[0] = '{w: 1,    a: 2,    n: 1, bub: 0, e32: 18,      s32: 0, e16: 18,     s16: 0};
    tbl[1] = '{w: 127,  a: 127,  n: 3, bub: 0, e32: 435483,  s32: 0, e16: 32767,  s16: 1};
    tbl[2] = '{w: 1,    a: 1,    n: 1, bub: 0, e32: 9,       s32: 0, e16: 9,      s16: 0};
    tbl[3] = '{w: -1,   a: 2,    n: 3, bub: 1, e32: -54,     s32: 0, e16: -54,    s16: 0};
    tbl[4] = '{w: -128, a: 127,  n: 1, bub: 0, e32: -146304, s32: 0, e16: -32768, s16: 1};
    tbl[5] = '{w: -128, a: -128, n: 1, bub: 0, e32: 147456,  s32: 0, e16: 32767,  s16: 1};
    tbl[6] = '{w: 5,    a: -3,   n: 2, bub: 1, e32: -270,    s32: 0, e16: -270,   s16: 0};

    set_all(0, 0);
    apply(1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    do_reset();
    chk("reset_psum", longint'(psum_a), 0);
    chk("reset_cnt", longint'(cnt_a), 0);

    // table vectors: uniform weights/activations, n channels per group
    for (int t = 0; t < 7; t++) begin
      set_all(tbl[t].w, 0);
      step(1'b1, 1'b0, 1'b0);
      p0 = npulse[0]; p1 = npulse[1];
      for (int j = 0; j < tbl[t].n; j++) begin
        set_all(tbl[t].w, tbl[t].a);
        step(1'b0, 1'b1, j == tbl[t].n - 1);
        if (tbl[t].bub && j < tbl[t].n - 1) step(1'b0, 1'b0, 1'b1);
      end
      repeat (4) step(1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_pulses32", t), npulse[0] - p0, 1);
      chk($sformatf("tbl%0d_psum32", t), cap_p[0], tbl[t].e32);
      chk($sformatf("tbl%0d_sat32", t), longint'(cap_s[0]), longint'(tbl[t].s32));
      chk($sformatf("tbl%0d_pulses16", t), npulse[1] - p1, 1);
      chk($sformatf("tbl%0d_psum16", t), cap_p[1], tbl[t].e16);
      chk($sformatf("tbl%0d_sat16", t), longint'(cap_s[1]), longint'(tbl[t].s16));
    end

    // weights 1..9, four back-to-back channels of ones
    for (int i = 0; i < 9; i++) begin t_wgt[i] = i + 1; t_act[i] = 1; end
    step(1'b1, 1'b0, 1'b0);
    p0 = npulse[0];
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, j == 3);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("seq180_pulses", npulse[0] - p0, 1);
    chk("seq180_psum", cap_p[0], 180);
    chk("seq180_cnt", longint'(cnt_a), 0);

    // load in the same cycle as a window: old weights apply to that window
    set_all(1, 1);
    step(1'b1, 1'b0, 1'b0);
    set_all(3, 1);
    step(1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("ldsame_old", cap_p[0], 9);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("ldsame_new", cap_p[0], 27);

    // reset with two windows in flight
    set_all(1, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    p0 = npulse[0];
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk("rstflight_pulses", npulse[0] - p0, 1);
    chk("rstflight_psum", cap_p[0], 9);

    // random traffic, including loads, bubbles and a mid-run reset
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 9; i++) begin
        t_wgt[i] = int'($urandom_range(0, 255)) - 128;
        t_act[i] = int'($urandom_range(0, 255)) - 128;
      end
      step(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0);
      if (c == 300) do_reset();
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // long group: grp_cnt wraps past 255
    for (int i = 0; i < 9; i++) t_wgt[i] = int'($urandom_range(0, 7)) - 3;
    step(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 300; j++) begin
      for (int i = 0; i < 9; i++) t_act[i] = int'($urandom_range(0, 255)) - 128;
      step(1'b0, 1'b1, j == 299);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("wrap_cnt_end", longint'(cnt_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
